nx_fifo_wr_sched: RTL
=====================

Name: nx_fifo_wr_sched

Overview:
- Round-robin write scheduler that shares one nx_fifo_ctrl-managed FIFO among NUM_REQ producers.
- Grants at most one push per cycle and enforces a per-requester occupancy quota.
- Tracks the owner ID of every stored entry, so the consumer side gets the head entry's requester ID.
- Provides a flush sequence (stop granting, wait for drain, report done) used before reconfiguration.

Parameters:
NUM_REQ, 4, number of producers (2..16)
DEPTH, 16, FIFO depth; must equal the DEPTH of the controlled FIFO; need not be a power of 2
QUOTA, 8, max entries one requester may hold in the FIFO (1..DEPTH)
IW, $clog2(NUM_REQ), requester ID width (derived, localparam)
CW, $clog2(DEPTH+1), count width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req  in  NUM_REQ  per-requester push request, level; held until granted
flush  in  1  single-cycle pulse: begin flush sequence
clear  in  1  synchronous clear; same cycle as FIFO ctrl clear
fifo_free_slots  in  CW  free_slots from FIFO ctrl
fifo_empty  in  1  empty from FIFO ctrl
fifo_ren  in  1  consumer pop (same signal drives FIFO ctrl ren)
gnt  out  NUM_REQ  one-hot grant, combinational
fifo_wen  out  1  OR of gnt; drives FIFO ctrl wen
gnt_id  out  IW  binary index of gnt; valid when fifo_wen
head_id  out  IW  owner ID of FIFO head entry; valid when !fifo_empty
occ  out  NUM_REQ*CW  per-requester entry count, requester i at [i*CW +: CW]
quota_stall  out  NUM_REQ  req[i] && occ[i] >= QUOTA, combinational
busy  out  1  state != RUN
flush_done  out  1  one-cycle pulse when flush completes
pop_err  out  1  one-cycle registered pulse: fifo_ren while fifo_empty

Behaviour:
- Reset values: state=RUN, rr_ptr=0, wr_ptr=rd_ptr=0, all occ=0, flush_done=0, pop_err=0, id array 0.
- Combinational outputs: with req=0, gnt=0, fifo_wen=0 and gnt_id=0.
- Eligibility: requester i is eligible when req[i], occ[i] < QUOTA, fifo_free_slots != 0 and state == RUN.
  - Safe for one push per cycle because free_slots is registered.
- Arbitration: pick the first eligible index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - On a grant of index g: rr_ptr <= (g+1) mod NUM_REQ.
  - No grant: rr_ptr holds.
- Zero-latency grant: gnt and fifo_wen are asserted in the same cycle as req. The data mux uses gnt_id in that cycle.
- Push: id_mem[wr_ptr] <= gnt_id; wr_ptr advances, wrapping DEPTH-1 -> 0.
- Pop: when fifo_ren && !fifo_empty, rd_ptr advances with the same wrap. head_id = id_mem[rd_ptr].
- Occupancy update per cycle, per requester i:
  - +1 if pushed, -1 if the popped entry's ID == i.
  - Push and pop of the same i in one cycle: unchanged.
  - Counters never wrap. Decrement at 0 or increment at QUOTA is unreachable; covered by an assertion.
- Pop when empty: pointers and counts unchanged; pop_err=1 the next cycle.
- FSM:
  - RUN: on flush -> DRAIN (granting stops from the next cycle).
  - DRAIN: gnt forced 0. When fifo_empty and all occ==0 -> DONE.
  - DONE: flush_done=1 for one cycle -> RUN.
  - flush while in DRAIN/DONE is ignored.
  - flush in the same cycle as a grant: that grant completes.
- clear (any state), highest priority:
  - Pointers, occ and rr_ptr go to 0; state goes to RUN.
  - No flush_done is issued.
  - A grant in the same cycle is discarded by both this block and the FIFO ctrl.
- Asynchronous reset mid-flush: returns to RUN with no flush_done.

Decomposition:
- Package nx_fifo_sched_pkg holds:
  - state enum {RUN, DRAIN, DONE}
  - width helper functions for IW/CW
- Sub-module nx_rr_arb: parameterised NUM_REQ round-robin arbiter.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: one-hot gnt, binary gnt_id, any.
  - Combinational; rr_ptr update stays in the parent.
- Id array and pointers stay in the parent.

Test Plan:
- Fairness: NUM_REQ=4, req=4'b1111 held, free_slots large, ren=0 -> grants 0,1,2,3,0,1... with one push per cycle until quota stalls.
- Quota: only req[2] asserted, no pops -> 8 grants, then quota_stall[2]=1 and gnt=0. One pop of a requester-2 entry -> occ[2]=7 and a grant the next cycle.
- Full: fifo_free_slots=0 with req=4'b0011 -> gnt=0. Free_slots=1 -> exactly one grant, to the requester at rr_ptr or the next active.
- Wrap and head_id: DEPTH=6, push IDs 1,3,0,2,1,3 and pop interleaved over 20 cycles -> head_id matches push order across pointer wrap. occ sums equal FIFO used_slots every cycle.
- Flush: push 5 entries, pulse flush with req=4'b1111 held -> gnt=0 from the next cycle, busy=1. Pop 5 -> flush_done pulses exactly once, one cycle after empty and all occ==0; then granting resumes.
- Error/clear: fifo_ren with fifo_empty -> pop_err pulse, occ unchanged. clear mid-DRAIN with 3 entries -> occ=0, state RUN, no flush_done.

Source files
------------

// File: rtl/nx_fifo_sched_pkg.sv
// Shared types and width helpers for the FIFO write scheduler.
//   sched_state_t : scheduler FSM states (RUN, DRAIN, DONE)
//   id_width      : bits needed to hold a requester index (min 1)
//   cnt_width     : bits needed to hold a count 0..depth
//   ptr_width     : bits needed to hold a pointer 0..depth-1 (min 1)
package nx_fifo_sched_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/nx_rr_arb.sv
// Combinational round-robin arbiter.
//   elig   : per-requester eligibility
//   rr_ptr : index that has highest priority this cycle
//   gnt    : one-hot grant (zero when nothing is eligible)
//   gnt_id : binary index of the grant (zero when nothing is eligible)
//   any    : a grant was issued
// The priority pointer itself is owned by the parent.
module nx_rr_arb
    import nx_fifo_sched_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IW      = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_id,
    output logic               any
);

    int          pos;
    logic [IW-1:0] idx;

    // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first eligible wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        pos    = 0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = IW'(pos);
            if (!any && elig[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/nx_fifo_wr_sched.sv
// Round-robin write scheduler sharing one FIFO among NUM_REQ producers.
// Grants at most one push per cycle, limits each producer to QUOTA stored
// entries, remembers the owner of every stored entry and runs a flush
// (stop granting, wait for drain, pulse done).
//   req/gnt/gnt_id/fifo_wen  : producer side, zero-latency grant
//   fifo_free_slots/empty    : status from the FIFO controller
//   fifo_ren/head_id         : consumer pop and owner of the head entry
//   occ/quota_stall          : per-requester occupancy and quota stall
//   flush/busy/flush_done    : flush handshake
//   clear                    : synchronous clear, same cycle as FIFO clear
//   pop_err                  : registered pulse for a pop on an empty FIFO
module nx_fifo_wr_sched
    import nx_fifo_sched_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DEPTH   = 16,
    parameter int  QUOTA   = 8,
    localparam int IW      = id_width(NUM_REQ),
    localparam int CW      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic                  flush,
    input  logic                  clear,
    input  logic [CW-1:0]         fifo_free_slots,
    input  logic                  fifo_empty,
    input  logic                  fifo_ren,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  fifo_wen,
    output logic [IW-1:0]         gnt_id,
    output logic [IW-1:0]         head_id,
    output logic [NUM_REQ*CW-1:0] occ,
    output logic [NUM_REQ-1:0]    quota_stall,
    output logic                  busy,
    output logic                  flush_done,
    output logic                  pop_err
);

    localparam int            PW       = ptr_width(DEPTH);
    localparam logic [CW-1:0] QUOTA_C  = CW'(QUOTA);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_ID  = IW'(NUM_REQ - 1);

    sched_state_t       state_reg, state_next;
    logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]      occ_reg  [NUM_REQ];
    logic [CW-1:0]      occ_next [NUM_REQ];
    logic [IW-1:0]      id_mem   [DEPTH];
    logic               pop_err_reg;

    logic [NUM_REQ-1:0] elig, inc, dec, occ_zero;
    logic               any_gnt, push, pop, drained;
    logic [IW-1:0]      pop_id;

    nx_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .elig   (elig),
        .rr_ptr (rr_ptr_reg),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any_gnt)
    );

    // A grant coinciding with clear is dropped here and in the FIFO ctrl.
    assign push     = any_gnt && !clear;
    assign pop      = fifo_ren && !fifo_empty && !clear;
    assign pop_id   = id_mem[rd_ptr_reg];
    assign head_id  = pop_id;
    assign fifo_wen = any_gnt;
    assign drained  = fifo_empty && (&occ_zero);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            // free_slots is registered and at most one push happens per
            // cycle, so a non-zero value always covers this cycle's push.
            assign elig[gi] = req[gi] && (occ_reg[gi] < QUOTA_C) &&
                              (fifo_free_slots != '0) && (state_reg == RUN);
            assign quota_stall[gi] = req[gi] && (occ_reg[gi] >= QUOTA_C);
            assign inc[gi]      = push && (gnt_id == IW'(gi));
            assign dec[gi]      = pop && (pop_id == IW'(gi));
            assign occ_zero[gi] = (occ_reg[gi] == '0);
            assign occ[gi*CW +: CW] = occ_reg[gi];
            // Push and pop of the same owner cancel out.
            assign occ_next[gi] = clear ? '0 :
                                  (inc[gi] && !dec[gi]) ? occ_reg[gi] + 1'b1 :
                                  (dec[gi] && !inc[gi]) ? occ_reg[gi] - 1'b1 :
                                  occ_reg[gi];
`ifndef SYNTHESIS
            a_no_underflow: assert property (@(posedge clk) disable iff (rst || clear)
                !(dec[gi] && !inc[gi] && occ_reg[gi] == '0));
            a_no_overflow: assert property (@(posedge clk) disable iff (rst || clear)
                !(inc[gi] && occ_reg[gi] >= QUOTA_C));
`endif
        end
    endgenerate

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (clear) begin
            rr_ptr_next = '0;
        end else if (push) begin
            rr_ptr_next = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            RUN:     if (flush)   state_next = DRAIN;
            DRAIN:   if (drained) state_next = DONE;
            DONE:                 state_next = RUN;
            default:              state_next = RUN;
        endcase
        if (clear) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= RUN;
            rr_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            occ_reg     <= '{default: '0};
            pop_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            occ_reg     <= occ_next;
            pop_err_reg <= fifo_ren && fifo_empty;
            if (clear) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
                end
            end
        end
    end

    // Owner-ID array: one entry per FIFO slot, written on push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_mem <= '{default: '0};
        end else if (push) begin
            id_mem[wr_ptr_reg] <= gnt_id;
        end
    end

    assign busy       = (state_reg != RUN);
    assign flush_done = (state_reg == DONE) && !clear;
    assign pop_err    = pop_err_reg;

endmodule
